dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
//  Controls the single L1-D cache port. Two requesters share it: speculative loads from the
//  Load/Store stage, and draining of retired stores at the store-buffer head. It issues one
//  cache transaction at a time with a req/ready + done handshake. It pops the store-buffer
//  head on store completion and discards load responses that were squashed by a mispredict.
//  An anti-starvation counter guarantees forward progress of store draining.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive load grants allowed while a store is pending; then store is forced
//  CNT_W         3  width of starvation counter (must hold STARVE_LIMIT)
// PORTS
//  CLK            in   1   clock
//  RST            in   1   reset, synchronous, active-high
//  flush          in   1   branch mispredict (clear_speculative); squashes in-flight load
//  ld_req         in   1   load wants the port (level; held until ld_gnt)
//  ld_addr        in   16  load address, sampled on ld_gnt
//  ld_gnt         out  1   one-cycle pulse: load accepted by arbiter
//  ld_data_valid  out  1   one-cycle pulse: ld_data holds load result
//  ld_data        out  16  load result (registered)
//  sb_head_valid  in   1   store-buffer head valid&executed&retired
//  sb_head_addr   in   16  head store address
//  sb_head_data   in   16  head store data
//  sb_full        in   1   store-buffer stall indication (pressure hint)
//  sb_pop_head    out  1   one-cycle pulse: head written to cache, advance head
//  dc_req         out  1   cache request valid
//  dc_we          out  1   1=store, 0=load
//  dc_addr        out  16  cache address (registered)
//  dc_wdata       out  16  store data (registered)
//  dc_ready       in   1   cache accepts request this cycle (dc_req&&dc_ready = accept)
//  dc_done        in   1   transaction complete (any cycle >= accept cycle +1)
//  dc_rdata       in   16  load data, valid with dc_done
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0, kill=0, all outputs 0 (ld_data, dc_addr, dc_wdata =16'h0).
//  - Reset mid-transaction abandons it; no pop, no ld_data_valid afterwards.
//  - FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT.
//  - IDLE arbitration (combinational, same cycle):
//    store_pri = sb_head_valid && (starve_cnt>=STARVE_LIMIT || sb_full || !ld_req).
//    If store_pri, go to ST_REQ and latch head addr/data.
//    Else if ld_req && !flush, pulse ld_gnt, latch ld_addr, go to LD_REQ.
//    ld_req is ignored while flush is high.
//  - LD_REQ/ST_REQ: dc_req=1, dc_we=(ST_REQ). Once raised, dc_req holds until dc_ready.
//    No withdrawal, even on flush. On dc_ready, go to LD_WAIT/ST_WAIT.
//  - LD_WAIT on dc_done: go to IDLE. Next cycle, ld_data<=dc_rdata and ld_data_valid=1,
//    unless kill is set.
//  - ST_WAIT on dc_done: sb_pop_head=1 that same cycle; go to IDLE.
//  - kill: set by flush in LD_REQ/LD_WAIT; cleared on entry to IDLE. flush in ST_* has no effect.
//    Retired stores are never speculative.
//  - A dc_done that arrives in the same cycle as flush is also squashed.
//  - starve_cnt: +1 (saturating at 2^CNT_W-1) on each ld_gnt while sb_head_valid.
//    Reset to 0 on a store grant or when !sb_head_valid.
//  - Back-to-back: earliest new grant is the cycle IDLE is re-entered. Min load latency is
//    grant->dc_req +1, done->ld_data_valid +1.
//  - Port never holds more than one outstanding transaction.
//    sb_pop_head and ld_data_valid are never high in the same cycle.
// TESTING
//  1 Load only: ld_req, ld_addr=16'h0040, dc_ready=1, dc_done 2 cyc later with rdata=16'hBEEF
//    -> ld_gnt@t0, dc_req@t1, ld_data_valid&ld_data=16'hBEEF one cycle after dc_done.
//  2 Store drain: sb_head_valid, addr=16'h0010, data=16'h1234, no ld_req
//    -> dc_req&dc_we, dc_addr=16'h0010, dc_wdata=16'h1234, sb_pop_head one pulse on dc_done.
//  3 Starvation: ld_req held high and sb_head_valid high -> 4 load grants, then store forced
//    on the 5th arbitration; starve_cnt returns to 0.
//  4 Flush in LD_WAIT: flush pulse before dc_done=1 -> no ld_data_valid; FSM back to IDLE;
//    next store issues normally.
//  5 dc_ready low 3 cycles in ST_REQ with flush pulsed -> dc_req stable and addr/data unchanged;
//    store completes with exactly one sb_pop_head.
//  6 RST asserted in LD_WAIT, then dc_done -> all outputs 0, no ld_data_valid, state IDLE.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - L1-D cache port arbiter between speculative loads and store-buffer drain
module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    output logic        ld_gnt,
    output logic        ld_data_valid,
    output logic [15:0] ld_data,
    input  logic        sb_head_valid,
    input  logic [15:0] sb_head_addr,
    input  logic [15:0] sb_head_data,
    input  logic        sb_full,
    output logic        sb_pop_head,
    output logic        dc_req,
    output logic        dc_we,
    output logic [15:0] dc_addr,
    output logic [15:0] dc_wdata,
    input  logic        dc_ready,
    input  logic        dc_done,
    input  logic [15:0] dc_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_REQ  = 3'd1,
        LD_WAIT = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic [CNT_W-1:0]   starve_cnt_d;
    logic               kill_q;
    logic               dc_req_q;
    logic               dc_we_q;
    logic [15:0]        dc_addr_q;
    logic [15:0]        dc_wdata_q;
    logic [15:0]        ld_data_q;
    logic               ld_data_valid_q;

    logic               store_pri;
    logic               st_gnt;
    logic               ld_gnt_w;
    logic               sb_pop_w;

    // Arbitration in IDLE, store pop strobe, and the starvation counter's next value
    always_comb begin
        store_pri = sb_head_valid && ((starve_cnt_q >= LIMIT) || sb_full || !ld_req);
        st_gnt    = !RST && (state_q == IDLE) && store_pri;
        ld_gnt_w  = !RST && (state_q == IDLE) && !store_pri && ld_req && !flush;
        sb_pop_w  = !RST && (state_q == ST_WAIT) && dc_done;

        starve_cnt_d = starve_cnt_q;
        if (!sb_head_valid || st_gnt) begin
            starve_cnt_d = '0;
        end else if (ld_gnt_w && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Port FSM: one outstanding transaction, registered cache-side and load-result outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            starve_cnt_q    <= '0;
            kill_q          <= 1'b0;
            dc_req_q        <= 1'b0;
            dc_we_q         <= 1'b0;
            dc_addr_q       <= 16'h0;
            dc_wdata_q      <= 16'h0;
            ld_data_q       <= 16'h0;
            ld_data_valid_q <= 1'b0;
        end else begin
            ld_data_valid_q <= 1'b0;
            starve_cnt_q    <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (st_gnt) begin
                        state_q    <= ST_REQ;
                        dc_req_q   <= 1'b1;
                        dc_we_q    <= 1'b1;
                        dc_addr_q  <= sb_head_addr;
                        dc_wdata_q <= sb_head_data;
                    end else if (ld_gnt_w) begin
                        state_q   <= LD_REQ;
                        dc_req_q  <= 1'b1;
                        dc_we_q   <= 1'b0;
                        dc_addr_q <= ld_addr;
                    end
                end
                LD_REQ: begin
                    // The request stays up even when squashed; only the result is dropped
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (dc_ready) begin
                        state_q  <= LD_WAIT;
                        dc_req_q <= 1'b0;
                    end
                end
                LD_WAIT: begin
                    if (dc_done) begin
                        state_q <= IDLE;
                        kill_q  <= 1'b0;
                        if (!(kill_q || flush)) begin
                            ld_data_valid_q <= 1'b1;
                            ld_data_q       <= dc_rdata;
                        end
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dc_ready) begin
                        state_q  <= ST_WAIT;
                        dc_req_q <= 1'b0;
                        dc_we_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (dc_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ld_gnt        = ld_gnt_w;
    assign sb_pop_head   = sb_pop_w;
    assign ld_data_valid = ld_data_valid_q;
    assign ld_data       = ld_data_q;
    assign dc_req        = dc_req_q;
    assign dc_we         = dc_we_q;
    assign dc_addr       = dc_addr_q;
    assign dc_wdata      = dc_wdata_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        ld_req = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic        ld_gnt;
    logic        ld_data_valid;
    logic [15:0] ld_data;
    logic        sb_head_valid = 1'b0;
    logic [15:0] sb_head_addr = 16'h0;
    logic [15:0] sb_head_data = 16'h0;
    logic        sb_full = 1'b0;
    logic        sb_pop_head;
    logic        dc_req;
    logic        dc_we;
    logic [15:0] dc_addr;
    logic [15:0] dc_wdata;
    logic        dc_ready = 1'b0;
    logic        dc_done = 1'b0;
    logic [15:0] dc_rdata = 16'h0;

    int errors = 0;
    int checks = 0;

    dcache_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .sb_head_valid(sb_head_valid), .sb_head_addr(sb_head_addr),
        .sb_head_data(sb_head_data), .sb_full(sb_full), .sb_pop_head(sb_pop_head),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_done(dc_done), .dc_rdata(dc_rdata)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: at most one transaction in flight, described by a record
    bit          m_valid = 1'b0;
    bit          m_active, m_store, m_acc, m_kill, m_ldv;
    logic [15:0] m_addr, m_wdata, m_ld_data;
    int          m_cnt;
    bit          e_sp, e_gnt, e_pop;
    logic [52:0] exp_v, act_v;

    always @(negedge CLK) begin
        e_sp  = sb_head_valid && (m_cnt >= 4 || sb_full || !ld_req);
        e_gnt = !RST && !m_active && !e_sp && ld_req && !flush;
        e_pop = !RST && m_active && m_store && m_acc && dc_done;
        if (m_valid) begin
            exp_v = {e_gnt, m_ldv, m_ld_data, e_pop, m_active && !m_acc,
                     m_active && !m_acc && m_store, m_addr, m_wdata};
            act_v = {ld_gnt, ld_data_valid, ld_data, sb_pop_head, dc_req, dc_we, dc_addr, dc_wdata};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle outputs @%0t: got %h expected %h", $time, act_v, exp_v);
            end
            checks++;
            if (sb_pop_head && ld_data_valid) begin
                errors++;
                $display("FAIL pop/valid overlap @%0t: got 1 expected 0", $time);
            end
        end
        if (RST) begin
            m_valid = 1'b1; m_active = 0; m_store = 0; m_acc = 0; m_kill = 0; m_ldv = 0;
            m_addr = 16'h0; m_wdata = 16'h0; m_ld_data = 16'h0; m_cnt = 0;
        end else begin
            m_ldv = 0;
            if (!m_active) begin
                m_kill = 0;
                if (e_sp) begin
                    m_active = 1; m_store = 1; m_acc = 0;
                    m_addr = sb_head_addr; m_wdata = sb_head_data; m_cnt = 0;
                end else if (ld_req && !flush) begin
                    m_active = 1; m_store = 0; m_acc = 0; m_addr = ld_addr;
                    if (sb_head_valid && m_cnt < 7) m_cnt = m_cnt + 1;
                end
            end else if (!m_acc) begin
                if (!m_store && flush) m_kill = 1;
                if (dc_ready) m_acc = 1;
            end else if (dc_done) begin
                if (!m_store && !(m_kill || flush)) begin
                    m_ldv = 1; m_ld_data = dc_rdata;
                end
                m_active = 0; m_kill = 0;
            end else if (!m_store && flush) begin
                m_kill = 1;
            end
            if (!sb_head_valid) m_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    initial begin
        int  runs[2];
        int  gcount, nstores, npop, wcnt;
        bit  accp, outstanding, prev_gnt, prev_pop;
        runs[0] = -1; runs[1] = -1;

        // reset
        repeat (3) tick();
        look();
        chk("reset outputs", {ld_gnt, ld_data_valid, ld_data, sb_pop_head, dc_req, dc_we, dc_addr, dc_wdata}, 64'h0);
        tick(); RST = 0;

        // 1: single load
        ld_req = 1; ld_addr = 16'h0040; dc_ready = 1; look();
        chk("t1 ld_gnt", ld_gnt, 1);
        tick(); ld_req = 0; look();
        chk("t1 dc_req", {dc_req, dc_we, dc_addr}, {1'b1, 1'b0, 16'h0040});
        tick(); look();
        chk("t1 req dropped", dc_req, 0);
        tick(); dc_done = 1; dc_rdata = 16'hBEEF; look();
        chk("t1 no early valid", ld_data_valid, 0);
        tick(); dc_done = 0; look();
        chk("t1 ld_data", {ld_data_valid, ld_data}, {1'b1, 16'hBEEF});
        tick(); look();
        chk("t1 valid pulse", ld_data_valid, 0);

        // 2: store drain
        tick(); sb_head_valid = 1; sb_head_addr = 16'h0010; sb_head_data = 16'h1234; look();
        chk("t2 no ld_gnt", ld_gnt, 0);
        tick(); look();
        chk("t2 store req", {dc_req, dc_we, dc_addr, dc_wdata}, {2'b11, 16'h0010, 16'h1234});
        tick(); dc_done = 1; look();
        chk("t2 pop", sb_pop_head, 1);
        tick(); dc_done = 0; sb_head_valid = 0; look();
        chk("t2 pop pulse", sb_pop_head, 0);

        // 3: starvation guard
        gcount = 0; nstores = 0; accp = 0;
        for (int c = 0; c < 80 && nstores < 2; c++) begin
            tick();
            if (c == 0) begin
                ld_req = 1; sb_head_valid = 1; sb_head_addr = 16'h0100;
                sb_head_data = 16'h0AAA; dc_ready = 1; ld_addr = 16'h0200;
            end
            dc_done = accp;
            look();
            if (ld_gnt) gcount++;
            if (dc_req && dc_we) begin
                runs[nstores] = gcount; nstores++; gcount = 0;
            end
            accp = dc_req && dc_ready;
        end
        chk("t3 grants before first forced store", runs[0], 4);
        chk("t3 grants before second forced store", runs[1], 4);
        tick(); dc_done = 1; ld_req = 0; look();
        chk("t3 store pop", sb_pop_head, 1);
        tick(); dc_done = 0; sb_head_valid = 0; look();

        // 4: flush during LD_WAIT
        tick(); ld_req = 1; ld_addr = 16'h0080; dc_ready = 1; look();
        chk("t4 gnt", ld_gnt, 1);
        tick(); ld_req = 0; look();
        tick(); flush = 1; look();
        tick(); flush = 0; dc_done = 1; dc_rdata = 16'hDEAD; look();
        tick(); dc_done = 0; sb_head_valid = 1; sb_head_addr = 16'h0020; sb_head_data = 16'h5555; look();
        chk("t4 squashed", ld_data_valid, 0);
        tick(); look();
        chk("t4 store after flush", {dc_req, dc_we, dc_addr, dc_wdata}, {2'b11, 16'h0020, 16'h5555});
        tick(); dc_done = 1; look();
        chk("t4 pop", sb_pop_head, 1);
        tick(); dc_done = 0; sb_head_valid = 0; look();

        // 5: stalled store with flush
        tick(); sb_head_valid = 1; sb_head_addr = 16'h0030; sb_head_data = 16'hA5A5; dc_ready = 0; look();
        npop = 0;
        for (int c = 0; c < 3; c++) begin
            tick(); sb_head_addr = 16'hFFFF; sb_head_data = 16'h0000; flush = (c == 1); look();
            chk("t5 held", {dc_req, dc_we, dc_addr, dc_wdata}, {2'b11, 16'h0030, 16'hA5A5});
            npop += int'(sb_pop_head);
        end
        tick(); flush = 0; dc_ready = 1; look();
        chk("t5 accept", {dc_req, dc_we, dc_addr, dc_wdata}, {2'b11, 16'h0030, 16'hA5A5});
        tick(); dc_done = 1; look(); npop += int'(sb_pop_head);
        tick(); dc_done = 0; sb_head_valid = 0; look(); npop += int'(sb_pop_head);
        for (int c = 0; c < 2; c++) begin
            tick(); look(); npop += int'(sb_pop_head);
        end
        chk("t5 pops", npop, 1);

        // 6: reset during LD_WAIT
        tick(); ld_req = 1; ld_addr = 16'h0090; dc_ready = 1; look();
        chk("t6 gnt", ld_gnt, 1);
        tick(); ld_req = 0; look();
        tick(); RST = 1; look();
        tick(); RST = 0; dc_done = 1; dc_rdata = 16'h7777; look();
        chk("t6 reset outputs", {ld_gnt, ld_data_valid, ld_data, sb_pop_head, dc_req, dc_we, dc_addr, dc_wdata}, 64'h0);
        tick(); dc_done = 0; ld_req = 1; ld_addr = 16'h00A0; look();
        chk("t6 no valid", ld_data_valid, 0);
        chk("t6 idle grant", ld_gnt, 1);
        tick(); ld_req = 0; look();
        tick(); dc_done = 1; dc_rdata = 16'h1357; look();
        tick(); dc_done = 0; look();
        chk("t6 post-reset load", {ld_data_valid, ld_data}, {1'b1, 16'h1357});

        // random traffic against the reference
        accp = 0; outstanding = 0; wcnt = 0; prev_gnt = 0; prev_pop = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            RST = ($urandom % 400) == 0;
            if (RST) begin
                outstanding = 0; accp = 0;
            end
            if (accp) begin
                outstanding = 1; wcnt = int'($urandom % 4);
            end
            dc_done = outstanding && (wcnt == 0) && !RST;
            if (dc_done) outstanding = 0;
            else if (outstanding) wcnt--;
            dc_rdata = 16'($urandom);
            dc_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 8) == 0;
            sb_full  = ($urandom % 6) == 0;
            if (prev_gnt || !ld_req) begin
                ld_req = ($urandom % 2) == 0;
                ld_addr = 16'($urandom);
            end
            if (prev_pop || !sb_head_valid) begin
                sb_head_valid = ($urandom % 3) == 0;
                sb_head_addr = 16'($urandom);
                sb_head_data = 16'($urandom);
            end
            look();
            prev_gnt = ld_gnt;
            prev_pop = sb_pop_head;
            accp = dc_req && dc_ready && !RST;
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
